md_ctrl: RTL

- Sequencing controller for the multiply/divide unit of the Yinger MIPS core.
- Owns the HI/LO registers.
- Executes MULT, MULTU, DIV, DIVU iteratively over 32 cycles; handles MFHI, MFLO, MTHI, MTLO.
- Issues a stall to the execute stage on any HI/LO hazard.
- Sits beside the ALU in EX; fed by the same funct field that drives ALU control decode.

---
 rtl/md_pkg.sv | 39 +++
 rtl/md_step.sv | 36 +++
 rtl/md_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide controller:
// funct codes, FSM states and operation kinds.
package md_pkg;

    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10
    } state_e;

    // bit 1 selects divide, bit 0 selects unsigned
    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    function automatic logic fn_known(input logic [5:0] f);
        logic k;
        k = 1'b0;
        case (f)
            FN_MULT, FN_MULTU, FN_DIV, FN_DIVU,
            FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO: k = 1'b1;
            default: k = 1'b0;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/md_step.sv
// One iteration of the multiplier (shift-add) or the
// restoring divider, on a 2*WIDTH-bit accumulator.
module md_step
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               div_i,
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   opnd_i,
    output logic [2*WIDTH-1:0] acc_o
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shl;
    logic [WIDTH:0]   diff;
    logic             ge;
    logic [WIDTH-1:0] rem;

    // Divide layout: {remainder, quotient/dividend}; the shifted
    // remainder stays below 2*divisor, so diff's top bit is the borrow.
    always_comb begin
        sum   = {1'b0, acc_i[2*WIDTH-1:WIDTH]}
              + (acc_i[0] ? {1'b0, opnd_i} : '0);
        shl   = acc_i[2*WIDTH-1:WIDTH-1];
        diff  = shl - {1'b0, opnd_i};
        ge    = ~diff[WIDTH];
        rem   = ge ? diff[WIDTH-1:0] : shl[WIDTH-1:0];
        if (div_i) begin
            acc_o = {rem, acc_i[WIDTH-2:0], ge};
        end else begin
            acc_o = {sum, acc_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/md_ctrl.sv
// Multiply/divide sequencer: owns HI/LO, runs 32-step
// mult/div, serves MFHI/MFLO/MTHI/MTLO and stalls EX on hazards.
module md_ctrl
    import md_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             md_valid,
    input  logic [5:0]       md_funct,
    input  logic [WIDTH-1:0] md_rs,
    input  logic [WIDTH-1:0] md_rt,
    input  logic             md_flush,
    output logic             md_stall,
    output logic             md_busy,
    output logic             md_done,
    output logic [WIDTH-1:0] md_rdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_e             state_q;
    logic [CNT_W-1:0]   count_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   opb_q;
    logic [WIDTH-1:0]   rs_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic [WIDTH-1:0]   hi_d;
    logic [WIDTH-1:0]   lo_d;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    op_e                op_q;
    op_e                op_dec;
    logic               neg_q;
    logic               rneg_q;
    logic               dz_q;
    logic               known;
    logic               is_md;
    logic               sa;
    logic               sb;
    logic               accept;
    logic               div_zero;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;

    always_comb begin
        is_md  = 1'b0;
        op_dec = OP_MULT;
        case (md_funct)
            FN_MULT:  begin is_md = 1'b1; op_dec = OP_MULT;  end
            FN_MULTU: begin is_md = 1'b1; op_dec = OP_MULTU; end
            FN_DIV:   begin is_md = 1'b1; op_dec = OP_DIV;   end
            FN_DIVU:  begin is_md = 1'b1; op_dec = OP_DIVU;  end
            default:  ;
        endcase
    end

    assign known    = fn_known(md_funct);
    assign sa       = ~op_dec[0] & md_rs[WIDTH-1];
    assign sb       = ~op_dec[0] & md_rt[WIDTH-1];
    assign mag_a    = sa ? -md_rs : md_rs;
    assign mag_b    = sb ? -md_rt : md_rt;
    assign div_zero = op_dec[1] & (md_rt == '0);
    assign accept   = md_valid & known & ~md_flush
                    & (state_q == ST_IDLE);

    md_step #(.WIDTH(WIDTH)) u_step (
        .div_i  (op_q[1]),
        .acc_i  (acc_q),
        .opnd_i (opb_q),
        .acc_o  (acc_nxt)
    );

    // Sign fixup applied in FIX; remainder follows the dividend.
    always_comb begin
        prod = neg_q ? -acc_q : acc_q;
        quo  = acc_q[WIDTH-1:0];
        rem  = acc_q[2*WIDTH-1:WIDTH];
        if (dz_q) begin
            hi_d = rs_q;
            lo_d = '1;
        end else if (op_q[1]) begin
            hi_d = rneg_q ? -rem : rem;
            lo_d = neg_q ? -quo : quo;
        end else begin
            {hi_d, lo_d} = prod;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            acc_q   <= '0;
            opb_q   <= '0;
            rs_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            op_q    <= OP_MULT;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (md_funct == FN_MTHI) hi_q <= md_rs;
                        if (md_funct == FN_MTLO) lo_q <= md_rs;
                        if (is_md) begin
                            acc_q   <= {{WIDTH{1'b0}}, mag_a};
                            opb_q   <= mag_b;
                            rs_q    <= md_rs;
                            op_q    <= op_dec;
                            neg_q   <= sa ^ sb;
                            rneg_q  <= sa;
                            dz_q    <= div_zero;
                            count_q <= '0;
                            state_q <= div_zero ? ST_FIX : ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    if (md_flush) begin
                        state_q <= ST_IDLE;
                        count_q <= '0;
                    end else begin
                        acc_q   <= acc_nxt;
                        count_q <= count_q + 1'b1;
                        if (count_q == CNT_W'(WIDTH - 1)) begin
                            state_q <= ST_FIX;
                        end
                    end
                end
                ST_FIX: begin
                    state_q <= ST_IDLE;
                    count_q <= '0;
                    if (!md_flush) begin
                        hi_q <= hi_d;
                        lo_q <= lo_d;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        md_rdata = '0;
        case (md_funct)
            FN_MFHI: md_rdata = hi_q;
            FN_MFLO: md_rdata = lo_q;
            default: md_rdata = '0;
        endcase
    end

    assign md_busy  = (state_q != ST_IDLE);
    assign md_done  = (state_q == ST_FIX) & ~md_flush;
    assign md_stall = md_valid & known & md_busy;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule
